cp_remover: RTL and testbench

- Receive-side counterpart of the cyclic-prefix inserter. It consumes the CP-extended sample stream and emits only the payload samples of each OFDM symbol.
- A symbol is cp_length prefix samples followed by frame_length payload samples. The block strips the prefix, marks the last payload sample of each symbol and counts symbols.
- It sits between the channel/loopback sample interface and the receive FFT. It uses valid/ready handshakes on both sides with a 2-entry output skid buffer, so backpressure never loses samples.

---
 rtl/cp_remover.sv | 110 +++++++++++
 tb/tb_cp_remover.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_remover.sv
// cp_remover: strips the cyclic prefix from a CP-extended OFDM sample stream
module cp_remover #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] signal_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [LEN_WIDTH-1:0]  cp_length,
    input  logic [LEN_WIDTH-1:0]  frame_length,
    output logic [DATA_WIDTH-1:0] signal_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  last_out,
    output logic                  cp_flag,
    output logic [15:0]           symbol_count,
    output logic                  error
);
    typedef enum logic [2:0] {IDLE, LOAD, DROP, PASS, ERR} state_t;

    state_t                state, state_n, cfg_state;
    logic [LEN_WIDTH-1:0]  cp_q, fl_q, pos;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last, skid_valid;
    logic                  accept, push, pop, drop_end, pass_end;
    logic [1:0]            occ, occ_n;

    assign accept    = valid_in && ready_out;
    assign push      = accept && state == PASS;
    assign pop       = valid_out && ready_in;
    assign drop_end  = accept && state == DROP && pos == cp_q - LEN_WIDTH'(1);
    assign pass_end  = push && pos == fl_q - LEN_WIDTH'(1);
    assign occ       = {1'b0, valid_out} + {1'b0, skid_valid};
    assign occ_n     = occ + {1'b0, push} - {1'b0, pop};
    assign cfg_state = (frame_length == '0 || cp_length > frame_length) ? ERR :
                       (cp_length != '0 ? DROP : PASS);

    // next state; symbol starts re-check the live configuration so symbols run back to back
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = LOAD;
            LOAD:    state_n = cfg_state;
            DROP:    state_n = drop_end ? PASS : DROP;
            PASS:    state_n = pass_end ? cfg_state : PASS;
            default: state_n = ERR;
        endcase
    end

    // symbol sequencing, latched configuration and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cp_q         <= '0;
            fl_q         <= '0;
            pos          <= '0;
            symbol_count <= '0;
            cp_flag      <= 1'b0;
            error        <= 1'b0;
            ready_out    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == LOAD || pass_end) begin
                cp_q <= cp_length;
                fl_q <= frame_length;
            end
            pos          <= (drop_end || pass_end) ? '0 : (accept ? pos + LEN_WIDTH'(1) : pos);
            symbol_count <= pass_end ? symbol_count + 16'd1 : symbol_count;
            cp_flag      <= state_n == DROP;
            error        <= state_n == ERR;
            ready_out    <= (state_n == DROP || state_n == PASS) && occ_n != 2'd2;
        end
    end

    // two-entry output buffer: the output register is the head, skid holds the overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signal_out <= '0;
            last_out   <= 1'b0;
            valid_out  <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!valid_out || pop) begin
            if (skid_valid) begin
                signal_out <= skid_data;
                last_out   <= skid_last;
                valid_out  <= 1'b1;
                skid_valid <= push;
                if (push) begin
                    skid_data <= signal_in;
                    skid_last <= pass_end;
                end
            end else if (push) begin
                signal_out <= signal_in;
                last_out   <= pass_end;
                valid_out  <= 1'b1;
            end else begin
                last_out  <= 1'b0;
                valid_out <= 1'b0;
            end
        end else if (push) begin
            skid_data  <= signal_in;
            skid_last  <= pass_end;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cp_remover.sv
// tb_cp_remover: randomized checks of cp_remover against a symbol-position reference model
module tb_cp_remover;
    localparam int DW = 32;
    localparam int LW = 13;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] signal_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [LW-1:0] cp_length = '0;
    logic [LW-1:0] frame_length = '0;
    logic [DW-1:0] signal_out;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic          last_out;
    logic          cp_flag;
    logic [15:0]   symbol_count;
    logic          error;

    int   checks = 0;
    int   errors = 0;
    int   rpat[7] = '{1, 1, 0, 1, 0, 0, 1};
    smp_t out_q[$];
    int   out_cyc[$];
    logic [DW-1:0] acc_d[$];
    logic acc_f[$];
    smp_t exp_q[$];
    logic exp_f[$];
    int   exp_syms;
    int   cyc = 0;
    int   stall_viol = 0;
    logic held = 1'b0;
    smp_t held_s;

    cp_remover #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .signal_in(signal_in), .valid_in(valid_in), .ready_out(ready_out),
        .cp_length(cp_length), .frame_length(frame_length), .signal_out(signal_out),
        .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out), .cp_flag(cp_flag),
        .symbol_count(symbol_count), .error(error)
    );

    always #5 clk = ~clk;

    // monitor: logs accepted inputs, popped outputs and stall-stability violations mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            acc_d.delete(); acc_f.delete(); out_q.delete(); out_cyc.delete();
            stall_viol = 0;
            held = 1'b0;
        end else begin
            if (valid_in && ready_out) begin
                acc_d.push_back(signal_in);
                acc_f.push_back(cp_flag);
            end
            if (held && (!valid_out || signal_out !== held_s.d || last_out !== held_s.l))
                stall_viol++;
            if (valid_out && ready_in) begin
                out_q.push_back('{signal_out, last_out});
                out_cyc.push_back(cyc);
            end
            held = valid_out && !ready_in;
            held_s = '{signal_out, last_out};
        end
    end

    // reference: walk accepted samples by position within symbol; first symbol uses cp0/fl0
    function automatic void model(input int cp0, input int fl0, input int cp1, input int fl1);
        int k = 0;
        int cp = cp0;
        int fl = fl0;
        exp_q.delete(); exp_f.delete(); exp_syms = 0;
        foreach (acc_d[i]) begin
            exp_f.push_back(k < cp);
            if (k >= cp) exp_q.push_back('{acc_d[i], k == cp + fl - 1});
            k++;
            if (k == cp + fl) begin
                k = 0; exp_syms++; cp = cp1; fl = fl1;
            end
        end
    endfunction

    task automatic do_reset(input int cp, input int fl);
        valid_in = 1'b0; ready_in = 1'b1; signal_in = '0;
        cp_length = LW'(cp); frame_length = LW'(fl);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic feed(input int base, input int n, input int vpct, input bit rtog, input bit rnd,
                        input int chg_at, input int chg_cp, output bit done);
        logic [DW-1:0] src[$];
        int idx = 0;
        int n_cyc = 0;
        bit a;
        for (int i = 0; i < n; i++) src.push_back(rnd ? DW'($urandom) : DW'(base + i));
        while (idx < n && n_cyc < 20000) begin
            if (idx == chg_at) cp_length = LW'(chg_cp);
            valid_in = $urandom_range(99) < vpct;
            signal_in = src[idx];
            ready_in = rtog ? (rpat[n_cyc % 7] != 0) : 1'b1;
            a = valid_in && ready_out;
            @(posedge clk); #1;
            if (a) idx++;
            n_cyc++;
        end
        valid_in = 1'b0; ready_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        done = idx == n;
    endtask

    task automatic test_reset();
        cp_length = LW'(4); frame_length = LW'(16);
        @(posedge clk); #2 rst = 1'b1;
        #3;
        checks++;
        if ({ready_out, valid_out, last_out, cp_flag, error} !== 5'b0 || symbol_count !== '0 || signal_out !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b last=%b cpf=%b err=%b cnt=%0d out=%h required all zero",
                     ready_out, valid_out, last_out, cp_flag, error, symbol_count, signal_out);
        end
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_out !== 1'b0) begin
            errors++; $display("FAIL reset_load_ready got %b required 0", ready_out);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_out !== 1'b1 || cp_flag !== 1'b1) begin
            errors++; $display("FAIL reset_drop_entry got rdy=%b cpf=%b required 1/1", ready_out, cp_flag);
        end
    endtask

    task automatic test_basic();
        bit done;
        int nf = 0;
        do_reset(4, 16);
        feed(0, 20, 100, 0, 0, -1, 0, done);
        model(4, 16, 4, 16);
        checks++;
        if (!done) begin errors++; $display("FAIL basic_feed got done=%b required 1", done); end
        checks++;
        if (out_q.size() != 16) begin errors++; $display("FAIL basic_count got %0d required 16", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_out[%0d] got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        foreach (acc_f[i]) nf += int'(acc_f[i]);
        checks++;
        if (nf != 4) begin errors++; $display("FAIL basic_cp_flag got %0d required 4", nf); end
        checks++;
        if (out_cyc.size() < 16 || out_cyc[15] - out_cyc[0] != 15) begin
            errors++; $display("FAIL basic_no_gaps got %0d outputs required 16 consecutive", out_cyc.size());
        end
        checks++;
        if (symbol_count !== 16'(exp_syms) || exp_syms != 1) begin
            errors++; $display("FAIL basic_symbols got %0d required 1", symbol_count);
        end
    endtask

    task automatic test_no_cp();
        bit done;
        int nf = 0;
        do_reset(0, 8);
        feed(0, 24, 100, 0, 1, -1, 0, done);
        model(0, 8, 0, 8);
        checks++;
        if (!done || out_q.size() != 24) begin
            errors++; $display("FAIL nocp_count got %0d required 24", out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL nocp_out[%0d] got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        foreach (acc_f[i]) nf += int'(acc_f[i]);
        checks++;
        if (nf != 0) begin errors++; $display("FAIL nocp_cp_flag got %0d required 0", nf); end
        checks++;
        if (symbol_count !== 16'd3) begin errors++; $display("FAIL nocp_symbols got %0d required 3", symbol_count); end
    endtask

    task automatic test_min_symbol();
        bit done;
        do_reset(0, 1);
        feed(0, 5, 100, 0, 1, -1, 0, done);
        model(0, 1, 0, 1);
        checks++;
        if (!done || out_q.size() != 5) begin errors++; $display("FAIL min_count got %0d required 5", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL min_out[%0d] got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        checks++;
        if (symbol_count !== 16'd5) begin errors++; $display("FAIL min_symbols got %0d required 5", symbol_count); end
    endtask

    task automatic test_backpressure();
        bit done;
        int bad = 0;
        do_reset(16, 64);
        feed(0, 800, 70, 1, 1, -1, 0, done);
        model(16, 64, 16, 64);
        checks++;
        if (!done || out_q.size() != 640) begin
            errors++; $display("FAIL bp_count got %0d required 640 (fed=%b)", out_q.size(), done);
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_out[%0d] got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        for (int i = 0; i < exp_f.size() && i < acc_f.size(); i++) bad += int'(acc_f[i] !== exp_f[i]);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_cp_flag got %0d wrong flags required 0", bad); end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes required 0", stall_viol); end
        checks++;
        if (symbol_count !== 16'd10) begin errors++; $display("FAIL bp_symbols got %0d required 10", symbol_count); end
    endtask

    task automatic test_error();
        bit done;
        int rdy = 0;
        int vld = 0;
        do_reset(20, 16);
        valid_in = 1'b1; signal_in = 32'h55;
        repeat (12) begin
            @(negedge clk);
            rdy += int'(ready_out);
            vld += int'(valid_out);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL err_flag got %b required 1", error); end
        checks++;
        if (rdy != 0 || vld != 0) begin
            errors++; $display("FAIL err_blocked got ready=%0d valid=%0d cycles required 0/0", rdy, vld);
        end
        do_reset(5, 0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || ready_out !== 1'b0) begin
            errors++; $display("FAIL err_zero_fl got err=%b rdy=%b required 1/0", error, ready_out);
        end
        do_reset(3, 3);
        feed(0, 12, 100, 0, 0, -1, 0, done);
        model(3, 3, 3, 3);
        checks++;
        if (error !== 1'b0 || !done || out_q.size() != 6) begin
            errors++; $display("FAIL err_recover got err=%b outputs=%0d required 0/6", error, out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL err_recover_out[%0d] got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        checks++;
        if (symbol_count !== 16'd2) begin errors++; $display("FAIL err_recover_symbols got %0d required 2", symbol_count); end
    endtask

    task automatic test_cfg_change();
        bit done;
        do_reset(4, 16);
        feed(0, 44, 100, 0, 0, 10, 8, done);
        model(4, 16, 8, 16);
        checks++;
        if (!done || out_q.size() != 32) begin errors++; $display("FAIL cfg_count got %0d required 32", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL cfg_out[%0d] got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        checks++;
        if (symbol_count !== 16'd2) begin errors++; $display("FAIL cfg_symbols got %0d required 2", symbol_count); end
    endtask

    task automatic test_async_reset();
        bit done;
        do_reset(4, 16);
        feed(0, 12, 100, 0, 0, -1, 0, done);
        checks++;
        if (!done || out_q.size() != 8) begin errors++; $display("FAIL areset_pre got %0d required 8", out_q.size()); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready_out, valid_out, last_out, cp_flag, error} !== 5'b0 || symbol_count !== '0 || signal_out !== '0) begin
            errors++;
            $display("FAIL areset_zero got rdy=%b vld=%b last=%b cpf=%b err=%b cnt=%0d out=%h required all zero",
                     ready_out, valid_out, last_out, cp_flag, error, symbol_count, signal_out);
        end
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        feed(100, 20, 100, 0, 0, -1, 0, done);
        model(4, 16, 4, 16);
        checks++;
        if (!done || out_q.size() != 16) begin errors++; $display("FAIL areset_count got %0d required 16", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL areset_out[%0d] got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        checks++;
        if (symbol_count !== 16'd1) begin errors++; $display("FAIL areset_symbols got %0d required 1", symbol_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_cp();
        test_min_symbol();
        test_backpressure();
        test_error();
        test_cfg_change();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
